// File: rtl/counter8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter8_pkg                                               |
// | Description : Shared opcodes, state encoding and widths for the counter  |
// |               sequencer and its prescaler.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package counter8_pkg;

  // Width of the counter datapath, load value and tick count.
  localparam int CNT_W = 8;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_RUN_UP   = 2'b10;
  localparam logic [1:0] OP_RUN_DOWN = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/counter8_presc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter8_presc                                             |
// | Description : Tick prescaler. Down-counter that parks at zero; clear     |
// |               beats load, load beats hold.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module counter8_presc #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  input  logic               hold,
  input  logic               clr,
  output logic               zero
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // Next count: clear, reload, or step down until zero is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - PRESC_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/counter8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter8_seq                                               |
// | Description : Command sequencer for the 8-bit counter core. Accepts      |
// |               LOAD / RUN commands over valid/ready and paces count ticks |
// |               through a programmable prescaler.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module counter8_seq
  import counter8_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_arg,
  input  logic [PRESC_W-1:0] div,
  input  logic               abort,
  output logic               cnt_load,
  output logic [CNT_W-1:0]   cnt_load_val,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   remaining
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   load_val_q, load_val_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic               up_q, up_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               live;
  logic               tick;
  logic               presc_zero;
  logic               presc_load;
  logic               presc_clr;
  logic               presc_hold;
  logic [PRESC_W-1:0] presc_val;

  // An abort or a low enable blanks every strobe in the same cycle.
  assign live      = ena & ~abort;
  assign cmd_ready = live & (state_q == IDLE);
  assign cnt_load  = live & (state_q == LOAD);
  assign tick      = live & (state_q == RUN) & presc_zero;
  assign cnt_en    = tick;

  // Next-state, latches and prescaler control; nothing moves while ena is low.
  always_comb begin
    state_d    = state_q;
    load_val_d = load_val_q;
    rem_d      = rem_q;
    div_d      = div_q;
    up_d       = up_q;
    done_d     = done_q;
    presc_load = 1'b0;
    presc_clr  = 1'b0;
    presc_val  = div_q;
    if (ena) begin
      done_d = 1'b0;
      if (abort) begin
        state_d   = IDLE;
        rem_d     = '0;
        presc_clr = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              case (cmd_op)
                OP_NOP:  done_d = 1'b1;
                OP_LOAD: begin
                  load_val_d = cmd_arg;
                  state_d    = LOAD;
                end
                // RUN_UP / RUN_DOWN; a zero tick count completes at once.
                default: begin
                  if (cmd_arg == '0) begin
                    done_d = 1'b1;
                  end else begin
                    up_d       = ~cmd_op[0];
                    rem_d      = cmd_arg;
                    div_d      = div;
                    presc_val  = div;
                    presc_load = 1'b1;
                    state_d    = RUN;
                  end
                end
              endcase
            end
          end
          LOAD: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          RUN: begin
            if (tick) begin
              presc_load = 1'b1;
              rem_d      = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  // The prescaler only counts down while running with the block enabled.
  assign presc_hold = ~ena | (state_q != RUN);

  counter8_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (presc_load),
    .load_val (presc_val),
    .hold     (presc_hold),
    .clr      (presc_clr),
    .zero     (presc_zero)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_val_q <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      up_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_val_q <= load_val_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      up_q       <= up_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign cnt_load_val = load_val_q;
  assign cnt_up       = up_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign remaining    = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_counter8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_counter8_seq                                            |
// | Description : Directed self-checking bench for counter8_seq. Per-cycle   |
// |               expectations are queued from the timing rules and popped   |
// |               at each falling edge.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_counter8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [3:0] div;
  logic       abort;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic       cnt_up;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  counter8_seq #(
    .PRESC_W (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .div          (div),
    .abort        (abort),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .busy         (busy),
    .done         (done),
    .remaining    (remaining)
  );

  always #5 clk = ~clk;

  // One expected cycle: ctl = {busy, done, cnt_en, cnt_load, cmd_ready};
  // negative rem/up/lval mean "not checked this cycle".
  typedef struct {
    string    tag;
    logic [4:0] ctl;
    int       rem;
    int       up;
    int       lval;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   en_seen  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit b, input bit d, input bit e,
                      input bit l, input bit r, input int rem, input int up, input int lval);
    exp_t x;
    x.tag  = tag;
    x.ctl  = {b, d, e, l, r};
    x.rem  = rem;
    x.up   = up;
    x.lval = lval;
    sb.push_back(x);
  endtask

  // Compare this cycle's outputs against the scoreboard, then advance one clock.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_ctl"}, {busy, done, cnt_en, cnt_load, cmd_ready}, e.ctl);
      if (e.rem  >= 0) check({e.tag, "_rem"},  remaining,    e.rem);
      if (e.up   >= 0) check({e.tag, "_up"},   cnt_up,       e.up);
      if (e.lval >= 0) check({e.tag, "_lval"}, cnt_load_val, e.lval);
    end
    if (cnt_en) en_seen++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_arg = 8'h00; div = 4'd0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en",   cnt_en, 0);
    check("rst_ld",   cnt_load, 0);
    check("rst_rem",  remaining, 0);
    check("rst_lval", cnt_load_val, 0);
    check("rst_up",   cnt_up, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD 0xA5: strobe in cycle 1, done in cycle 2.
    push("ld_c0", 0, 0, 0, 0, 1, 0, 0, 0);
    push("ld_c1", 1, 0, 0, 1, 0, 0, 0, 8'hA5);
    push("ld_c2", 0, 1, 0, 0, 1, 0, 0, 8'hA5);
    push("ld_c3", 0, 0, 0, 0, 1, 0, 0, 8'hA5);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'hA5;
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();

    // RUN_UP arg=3 div=2; div and op are scrambled after accept.
    for (int c = 0; c <= 11; c++) begin
      if (c == 0)       push("up_c0", 0, 0, 0, 0, 1, 0, -1, -1);
      else if (c <= 9)  push($sformatf("up_c%0d", c), 1, 0, (c % 3) == 0, 0, 0, 3 - (c - 1) / 3, 1, -1);
      else if (c == 10) push("up_c10", 0, 1, 0, 0, 1, 0, 1, -1);
      else              push("up_c11", 0, 0, 0, 0, 1, 0, 1, -1);
    end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd3; div = 4'd2;
    cycle();
    cmd_valid = 1'b0; cmd_op = 2'b11; div = 4'd0;
    repeat (11) cycle();

    // RUN_DOWN arg=4 div=0 with ena low in cycles 2..4.
    push("dn_c0", 0, 0, 0, 0, 1, 0, -1, -1);
    push("dn_c1", 1, 0, 1, 0, 0, 4, 0, -1);
    push("dn_c2", 1, 0, 0, 0, 0, 3, 0, -1);
    push("dn_c3", 1, 0, 0, 0, 0, 3, 0, -1);
    push("dn_c4", 1, 0, 0, 0, 0, 3, 0, -1);
    push("dn_c5", 1, 0, 1, 0, 0, 3, 0, -1);
    push("dn_c6", 1, 0, 1, 0, 0, 2, 0, -1);
    push("dn_c7", 1, 0, 1, 0, 0, 1, 0, -1);
    push("dn_c8", 0, 1, 0, 0, 1, 0, 0, -1);
    push("dn_c9", 0, 0, 0, 0, 1, 0, 0, -1);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 8'd4; div = 4'd0;
    cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      ena = !(c >= 2 && c <= 4);
      cycle();
    end
    ena = 1'b1;

    // RUN_UP arg=200 div=1, abort in cycle 11.
    for (int c = 0; c <= 13; c++) begin
      if (c == 0)       push("ab_c0", 0, 0, 0, 0, 1, 0, -1, -1);
      else if (c <= 11) push($sformatf("ab_c%0d", c), 1, 0, (c % 2) == 0, 0, 0, 200 - (c - 1) / 2, 1, -1);
      else              push($sformatf("ab_c%0d", c), 0, 0, 0, 0, 1, 0, 1, -1);
    end
    en_seen = 0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd200; div = 4'd1;
    cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      abort = (c == 11);
      cycle();
    end
    abort = 1'b0;
    check("ab_pulses", en_seen, 5);

    // Back-to-back NOP, RUN_UP arg=0, LOAD 0x00 with cmd_valid held.
    en_seen = 0;
    push("bb_c0", 0, 0, 0, 0, 1, 0, 1, 8'hA5);
    push("bb_c1", 0, 1, 0, 0, 1, 0, 1, 8'hA5);
    push("bb_c2", 0, 1, 0, 0, 1, 0, 1, 8'hA5);
    push("bb_c3", 1, 0, 0, 1, 0, 0, 1, 8'h00);
    push("bb_c4", 0, 1, 0, 0, 1, 0, 1, 8'h00);
    push("bb_c5", 0, 0, 0, 0, 1, 0, 1, 8'h00);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'h77;
    cycle();
    cmd_op = 2'b10; cmd_arg = 8'h00;
    cycle();
    cmd_op = 2'b01; cmd_arg = 8'h00;
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();
    check("bb_no_en", en_seen, 0);

    // Asynchronous reset in the middle of a RUN_UP arg=10 div=0.
    push("rs_c0", 0, 0, 0, 0, 1, 0, -1, -1);
    push("rs_c1", 1, 0, 1, 0, 0, 10, 1, -1);
    push("rs_c2", 1, 0, 1, 0, 0, 9, 1, -1);
    push("rs_c3", 1, 0, 1, 0, 0, 8, 1, -1);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd10; div = 4'd0;
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_en",   cnt_en, 0);
    check("rs_rem",  remaining, 0);
    check("rs_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("rs_post0", 0, 0, 0, 0, 1, 0, 0, 0);
    push("rs_post1", 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter8_seq.md
# counter8_seq

Command-driven sequencer for the 8-bit counter datapath in `tt_um_counter8`. It accepts load/run commands over a valid/ready port and drives the counter's load, enable and direction controls. A programmable prescaler paces count ticks. The block sits between the pin-decode logic and the counter core, so the counter holds no sequencing logic.

## Interface
- `PRESC_W`, default 4: width of the prescaler divide field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable. When low, all state is frozen and `cmd_ready`, `cnt_en` and `cnt_load` are 0.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid & cmd_ready`.
- `cmd_op` in 2: opcode. 00 NOP, 01 LOAD, 10 RUN_UP, 11 RUN_DOWN.
- `cmd_arg` in 8: load value (LOAD) or tick count (RUN_*).
- `div` in PRESC_W: tick period is div+1 cycles. Sampled only at command accept.
- `abort` in 1: synchronous cancel of the current command.
- `cnt_load` out 1: counter load strobe.
- `cnt_load_val` out 8: value to load.
- `cnt_en` out 1: counter count-enable, one cycle per tick.
- `cnt_up` out 1: count direction, 1 = up.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `remaining` out 8: ticks left in the current RUN.

## Operation
- States are IDLE, LOAD and RUN.
- Reset state: IDLE. All outputs 0, including `cnt_load_val`, `cnt_up`, `remaining` and the prescaler.
- `cmd_ready` = `ena & ~abort & (state==IDLE)`. This is combinational; `cmd_valid` must not depend on `cmd_ready`.
- On accept:
  - NOP: stay in IDLE, pulse `done` next cycle.
  - LOAD: latch `cnt_load_val` = arg, go to LOAD.
  - RUN_*: latch `cnt_up` = op[0]==0, `remaining` = arg, presc = div, go to RUN.
  - RUN_* with arg = 0: stay in IDLE, `done` next cycle, no `cnt_en`.
- LOAD: `cnt_load` = 1 for exactly one cycle, then IDLE with `done`.
- RUN: tick = `ena & (presc==0) & ~abort`, and `cnt_en` = tick.
  - On a tick: presc reloads div and `remaining` decrements.
  - If `remaining` was 1 on the tick, go to IDLE with `done`.
  - Otherwise, with `ena` high, presc decrements.
- `done` is registered. It is high in the first IDLE cycle after a completed command only. A new command may be accepted in that same cycle (back-to-back).
- Abort:
  - From any state, next state is IDLE.
  - No `done` is produced.
  - `cnt_en` and `cnt_load` are forced 0 in the abort cycle.
  - `remaining` and presc clear to 0.
  - `cnt_load_val` and `cnt_up` hold their values.
- `ena` low mid-RUN: presc and `remaining` hold, and no ticks occur. Counting resumes with no lost or extra ticks.
- `ena` low in LOAD: `cnt_load` is suppressed and the block stays in LOAD until `ena` returns.
- The counter's own wrap-around (255↔0) is not observed or limited here.
- `div` or `cmd_*` changing during RUN has no effect.

## Timing
- Accept edge = cycle 0. LOAD: `cnt_load` in cycle 1, `done` in cycle 2.
- RUN, continuous `ena`:
  - `cnt_en` in cycles k·(div+1), for k = 1..arg.
  - `done` in cycle arg·(div+1)+1.
  - `busy` is high in cycles 1 .. arg·(div+1).
- Minimum command-to-command spacing (NOP or arg = 0) is 1 cycle. `done` and the next accept can coincide.
- Abort asserted in cycle n: `busy` = 0 and `cmd_ready` = 1 (if `ena`) in cycle n+1.
- Reset asserted mid-RUN: outputs go to 0 immediately (asynchronous). There is no `done`.
- All outputs except `cmd_ready`, `cnt_en` and `cnt_load` are register outputs. Those three are single-level decodes of state, presc, `ena` and `abort`.

## Structure
- Package `counter8_pkg`:
  - Opcode constants OP_NOP, OP_LOAD, OP_RUN_UP, OP_RUN_DOWN.
  - State enum (IDLE, LOAD, RUN).
  - Counter width constant CNT_W = 8.
- Sub-module `counter8_presc`: PRESC_W-bit down-counter.
  - Inputs: `load`, `load_val`, `hold`, `clr`.
  - Output: `zero`.
  - The FSM, arg latch and `remaining` counter stay in `counter8_seq`.

## Test plan
- Reset, then LOAD arg = 0xA5: `cnt_load` = 1 in cycle 1 only with `cnt_load_val` = 0xA5; `done` in cycle 2; `busy` = 1 in cycle 1 only.
- RUN_UP arg = 3, div = 2: `cnt_en` in cycles 3, 6 and 9 with `cnt_up` = 1; `remaining` goes 3→2→1→0; `done` in cycle 10.
- RUN_DOWN arg = 4, div = 0, with `ena` low for cycles 2–4: `cnt_en` in cycles 1, 5, 6 and 7 with `cnt_up` = 0; `done` in cycle 8.
- RUN_UP arg = 200, div = 1, abort in cycle 11: exactly 5 `cnt_en` pulses; no `done`; `busy` = 0 and `cmd_ready` = 1 in cycle 12.
- Back-to-back NOP, then RUN_UP arg = 0, then LOAD 0x00, with `cmd_valid` held: accepts in cycles 0, 1 and 2; `done` in cycles 1, 2 and 4; no `cnt_en`.
- `rst_n` pulled low asynchronously mid-RUN: `busy`, `cnt_en` and `remaining` are 0 immediately; after release, the block is in IDLE with `cmd_ready` = 1.
